// File: rtl/alu_issue_slice_if.sv
// alu_issue_slice_if
// Issue-side and arbiter-side handshake bundle for one ALU issue slice.
// The tri-state CDB pins are not part of this bundle; they stay on the
// slice as plain inout ports because the bus is shared and resolved outside.
//
// Signals:
//   enable            issue strobe from the issue logic
//   q1_in / v1_in     producer tag / value for operand 1 (tag 0 = value valid)
//   q2_in / v2_in     producer tag / value for operand 2
//   funct3_in         RV32I ALU operation
//   sign_in           selects SUB / SRA
//   rob_tag_in        destination ROB tag
//   cdb_valid         CDB carries a valid broadcast this cycle
//   cdb_permit        arbiter grants the CDB to this slice
//   busy              station occupied
//   ready_to_execute  station can dispatch this cycle
//   buf_not_empty     output FIFO holds at least one result
//
// Modports:
//   master  issue logic / arbiter side
//   slave   the slice itself
interface alu_issue_slice_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32
);
  logic                 enable;
  logic [TAG_WIDTH-1:0] q1_in;
  logic [XLEN-1:0]      v1_in;
  logic [TAG_WIDTH-1:0] q2_in;
  logic [XLEN-1:0]      v2_in;
  logic [2:0]           funct3_in;
  logic                 sign_in;
  logic [TAG_WIDTH-1:0] rob_tag_in;
  logic                 cdb_valid;
  logic                 cdb_permit;
  logic                 busy;
  logic                 ready_to_execute;
  logic                 buf_not_empty;

  modport master (
    output enable, q1_in, v1_in, q2_in, v2_in, funct3_in, sign_in, rob_tag_in,
    output cdb_valid, cdb_permit,
    input  busy, ready_to_execute, buf_not_empty
  );

  modport slave (
    input  enable, q1_in, v1_in, q2_in, v2_in, funct3_in, sign_in, rob_tag_in,
    input  cdb_valid, cdb_permit,
    output busy, ready_to_execute, buf_not_empty
  );
endinterface

// File: rtl/alu_issue_slice.sv
// alu_issue_slice
// One out-of-order execution slice: a single-entry reservation station that
// snoops the common data bus for missing operands, a combinational RV32I
// integer ALU, and an output FIFO that drives the shared tri-state CDB when
// the arbiter grants it. The station frees itself when its own ROB tag is
// broadcast on the CDB.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   io           alu_issue_slice_if.slave (issue inputs, arbiter inputs, status)
//   cdb_rob_tag  CDB tag, tri-state (driven only while granted with data queued)
//   cdb_data     CDB data, tri-state
//
// Optional feature macro: ISSUE_CDB_FORWARD_EN
//   When defined, an issue whose operand tag is being broadcast in the same
//   cycle captures the CDB value directly instead of waiting for a snoop.
module alu_issue_slice #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_slice_if.slave     io,
  inout  wire  [TAG_WIDTH-1:0] cdb_rob_tag,
  inout  wire  [XLEN-1:0]      cdb_data
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int SHW   = $clog2(XLEN);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(BUF_DEPTH);

  logic [TAG_WIDTH-1:0] q1_q, q1_d, q2_q, q2_d, tag_q, tag_d;
  logic [XLEN-1:0]      v1_q, v1_d, v2_q, v2_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 sign_q, sign_d, busy_q, busy_d, dispatched_q, dispatched_d;

  logic [XLEN-1:0]      bufData_q [BUF_DEPTH];
  logic [TAG_WIDTH-1:0] bufTag_q  [BUF_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
  logic [PTR_W:0]       count_q;

  logic            issueHit, freeHit, snoop1, snoop2;
  logic            readyExec, fifoFull, accept, pop;
  logic [XLEN-1:0] aluResult;

  // Station event decode. Issue only lands in an empty station, while snoop
  // and free only act on an occupied one, so issue never races a snoop.
  // Tag 0 means "no producer", so it never matches a broadcast.
  assign issueHit  = io.enable & ~busy_q;
  assign freeHit   = busy_q & io.cdb_valid & (tag_q != '0) & (cdb_rob_tag == tag_q);
  assign snoop1    = busy_q & io.cdb_valid & (q1_q != '0) & (q1_q == cdb_rob_tag);
  assign snoop2    = busy_q & io.cdb_valid & (q2_q != '0) & (q2_q == cdb_rob_tag);
  assign readyExec = busy_q & (q1_q == '0) & (q2_q == '0) & ~dispatched_q;
  assign fifoFull  = (count_q == FULL_COUNT);
  assign accept    = readyExec & ~fifoFull;
  assign pop       = io.cdb_permit & (count_q != '0);

  assign io.busy             = busy_q;
  assign io.ready_to_execute = readyExec;
  assign io.buf_not_empty    = (count_q != '0);

  // Head of the FIFO owns the shared bus only while granted and non-empty;
  // otherwise the slice leaves the CDB floating for other drivers.
  assign cdb_data    = pop ? bufData_q[rdPtr_q] : 'z;
  assign cdb_rob_tag = pop ? bufTag_q[rdPtr_q]  : 'z;

  // Station next-state. Free wins over everything so a broadcast of our own
  // tag clears the entry even if a snoop would also match that cycle.
  // Dispatch only marks the entry as sent; it stays busy until freed.
  always_comb begin
    q1_d         = q1_q;
    v1_d         = v1_q;
    q2_d         = q2_q;
    v2_d         = v2_q;
    tag_d        = tag_q;
    funct3_d     = funct3_q;
    sign_d       = sign_q;
    busy_d       = busy_q;
    dispatched_d = dispatched_q;
    if (freeHit) begin
      q1_d         = '0;
      v1_d         = '0;
      q2_d         = '0;
      v2_d         = '0;
      tag_d        = '0;
      funct3_d     = '0;
      sign_d       = 1'b0;
      busy_d       = 1'b0;
      dispatched_d = 1'b0;
    end else begin
      if (issueHit) begin
        q1_d         = io.q1_in;
        v1_d         = (io.q1_in == '0) ? io.v1_in : '0;
        q2_d         = io.q2_in;
        v2_d         = (io.q2_in == '0) ? io.v2_in : '0;
`ifdef ISSUE_CDB_FORWARD_EN
        if (io.cdb_valid && (io.q1_in != '0) && (io.q1_in == cdb_rob_tag)) begin
          q1_d = '0;
          v1_d = cdb_data;
        end
        if (io.cdb_valid && (io.q2_in != '0) && (io.q2_in == cdb_rob_tag)) begin
          q2_d = '0;
          v2_d = cdb_data;
        end
`endif
        tag_d        = io.rob_tag_in;
        funct3_d     = io.funct3_in;
        sign_d       = io.sign_in;
        busy_d       = 1'b1;
        dispatched_d = 1'b0;
      end
      if (snoop1) begin
        q1_d = '0;
        v1_d = cdb_data;
      end
      if (snoop2) begin
        q2_d = '0;
        v2_d = cdb_data;
      end
      if (accept) begin
        dispatched_d = 1'b1;
      end
    end
  end

  // Station registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_q         <= '0;
      v1_q         <= '0;
      q2_q         <= '0;
      v2_q         <= '0;
      tag_q        <= '0;
      funct3_q     <= '0;
      sign_q       <= 1'b0;
      busy_q       <= 1'b0;
      dispatched_q <= 1'b0;
    end else begin
      q1_q         <= q1_d;
      v1_q         <= v1_d;
      q2_q         <= q2_d;
      v2_q         <= v2_d;
      tag_q        <= tag_d;
      funct3_q     <= funct3_d;
      sign_q       <= sign_d;
      busy_q       <= busy_d;
      dispatched_q <= dispatched_d;
    end
  end

  // RV32I integer ALU on the station operands. Shifts use only the low
  // log2(XLEN) bits of the second operand; arithmetic wraps naturally.
  always_comb begin
    aluResult = '0;
    unique case (funct3_q)
      3'b000: aluResult = sign_q ? (v1_q - v2_q) : (v1_q + v2_q);
      3'b001: aluResult = v1_q << v2_q[SHW-1:0];
      3'b010: aluResult = {{(XLEN-1){1'b0}}, ($signed(v1_q) < $signed(v2_q))};
      3'b011: aluResult = {{(XLEN-1){1'b0}}, (v1_q < v2_q)};
      3'b100: aluResult = v1_q ^ v2_q;
      3'b101: aluResult = sign_q ? XLEN'($signed(v1_q) >>> v2_q[SHW-1:0])
                                 : (v1_q >> v2_q[SHW-1:0]);
      3'b110: aluResult = v1_q | v2_q;
      3'b111: aluResult = v1_q & v2_q;
      default: aluResult = '0;
    endcase
  end

  // Output FIFO. Pointers are power-of-two wide so they wrap for free.
  // A simultaneous push and pop leaves the occupancy count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bufData_q[i] <= '0;
        bufTag_q[i]  <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        bufData_q[wrPtr_q] <= aluResult;
        bufTag_q[wrPtr_q]  <= tag_q;
        wrPtr_q            <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_slice.sv
// tb_alu_issue_slice
// Directed bench for alu_issue_slice: reset state, issue, CDB snooping,
// dispatch, bus drain with self-free, the ALU operation table, FIFO
// back-pressure with ordering across a wrap, and asynchronous reset.
module tb_alu_issue_slice;

  localparam int XLEN  = 32;
  localparam int TW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  // 10 ns clock; inputs are driven and outputs sampled around the negedge.
  always #5 clk = ~clk;

  alu_issue_slice_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) ifc ();

  wire  [TW-1:0]   cdbRobTag;
  wire  [XLEN-1:0] cdbData;
  logic            tbDrive;
  logic [TW-1:0]   tbTag;
  logic [XLEN-1:0] tbData;

  // The bench plays "another producer" on the shared bus when tbDrive is set.
  assign cdbRobTag = tbDrive ? tbTag  : 'z;
  assign cdbData   = tbDrive ? tbData : 'z;

  alu_issue_slice #(.XLEN(XLEN), .TAG_WIDTH(TW), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .io          (ifc.slave),
    .cdb_rob_tag (cdbRobTag),
    .cdb_data    (cdbData)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Present one issue request across a single rising edge.
  task automatic applyStimulus(input logic [TW-1:0] q1, input logic [XLEN-1:0] v1,
                               input logic [TW-1:0] q2, input logic [XLEN-1:0] v2,
                               input logic [2:0] f3, input logic sgn,
                               input logic [TW-1:0] tag);
    ifc.enable     = 1'b1;
    ifc.q1_in      = q1;
    ifc.v1_in      = v1;
    ifc.q2_in      = q2;
    ifc.v2_in      = v2;
    ifc.funct3_in  = f3;
    ifc.sign_in    = sgn;
    ifc.rob_tag_in = tag;
    @(negedge clk);
    ifc.enable = 1'b0;
  endtask

  // Broadcast a foreign tag/value on the CDB for one rising edge.
  task automatic applyBroadcast(input logic [TW-1:0] tag, input logic [XLEN-1:0] data);
    tbDrive       = 1'b1;
    tbTag         = tag;
    tbData        = data;
    ifc.cdb_valid = 1'b1;
    @(negedge clk);
    tbDrive       = 1'b0;
    ifc.cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    testsRun++;
    if (ifc.busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_busy: got %0h want 0", ifc.busy);
    end
    testsRun++;
    if (ifc.ready_to_execute !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_ready: got %0h want 0", ifc.ready_to_execute);
    end
    testsRun++;
    if (ifc.buf_not_empty !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_bne: got %0h want 0", ifc.buf_not_empty);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_issue();
    applyStimulus(TW'(10), 32'hDEAD_0001, TW'(12), 32'hBEEF_0002, 3'b000, 1'b0, TW'(19));
    testsRun++;
    if (dut.q1_q !== TW'(10)) begin
      testsFailed++; $display("[TB] FAIL issue_q1: got %0d want 10", dut.q1_q);
    end
    testsRun++;
    if (dut.v1_q !== 32'd0) begin
      testsFailed++; $display("[TB] FAIL issue_v1: got %0h want 0", dut.v1_q);
    end
    testsRun++;
    if (dut.q2_q !== TW'(12)) begin
      testsFailed++; $display("[TB] FAIL issue_q2: got %0d want 12", dut.q2_q);
    end
    testsRun++;
    if (dut.v2_q !== 32'd0) begin
      testsFailed++; $display("[TB] FAIL issue_v2: got %0h want 0", dut.v2_q);
    end
    testsRun++;
    if (ifc.busy !== 1'b1 || ifc.ready_to_execute !== 1'b0 || ifc.buf_not_empty !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL issue_status: got busy=%0h ready=%0h bne=%0h want 1 0 0",
               ifc.busy, ifc.ready_to_execute, ifc.buf_not_empty);
    end
    // A second issue while occupied must be ignored.
    applyStimulus(TW'(0), 32'd5, TW'(0), 32'd6, 3'b000, 1'b0, TW'(77));
    testsRun++;
    if (dut.tag_q !== TW'(19) || dut.q1_q !== TW'(10)) begin
      testsFailed++;
      $display("[TB] FAIL issue_while_busy: got tag=%0d q1=%0d want 19 10", dut.tag_q, dut.q1_q);
    end
  endtask

  task automatic test_snoop();
    applyBroadcast(TW'(10), 32'd24);
    testsRun++;
    if (dut.v1_q !== 32'd24 || dut.q1_q !== TW'(0)) begin
      testsFailed++;
      $display("[TB] FAIL snoop_op1: got v1=%0d q1=%0d want 24 0", dut.v1_q, dut.q1_q);
    end
    testsRun++;
    if (ifc.ready_to_execute !== 1'b0 || ifc.buf_not_empty !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL snoop_op1_status: got ready=%0h bne=%0h want 0 0",
               ifc.ready_to_execute, ifc.buf_not_empty);
    end
    applyBroadcast(TW'(12), 32'd17);
    testsRun++;
    if (dut.v2_q !== 32'd17 || ifc.ready_to_execute !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL snoop_op2: got v2=%0d ready=%0h want 17 1", dut.v2_q, ifc.ready_to_execute);
    end
    @(negedge clk);
    testsRun++;
    if (ifc.ready_to_execute !== 1'b0 || ifc.buf_not_empty !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL dispatch: got ready=%0h bne=%0h want 0 1",
               ifc.ready_to_execute, ifc.buf_not_empty);
    end
  endtask

  task automatic test_drain_free();
    ifc.cdb_permit = 1'b1;
    ifc.cdb_valid  = 1'b1;
    #1;
    testsRun++;
    if (cdbData !== 32'd41 || cdbRobTag !== TW'(19)) begin
      testsFailed++;
      $display("[TB] FAIL drain_bus: got data=%0d tag=%0d want 41 19", cdbData, cdbRobTag);
    end
    @(negedge clk);
    ifc.cdb_permit = 1'b0;
    ifc.cdb_valid  = 1'b0;
    testsRun++;
    if (ifc.busy !== 1'b0 || ifc.buf_not_empty !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL free_status: got busy=%0h bne=%0h want 0 0", ifc.busy, ifc.buf_not_empty);
    end
    testsRun++;
    if (dut.tag_q !== TW'(0) || dut.v1_q !== 32'd0 || dut.v2_q !== 32'd0 || dut.dispatched_q !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL free_fields: got tag=%0d v1=%0d v2=%0d disp=%0h want 0 0 0 0",
               dut.tag_q, dut.v1_q, dut.v2_q, dut.dispatched_q);
    end
  endtask

  task automatic test_both_operands();
    applyStimulus(TW'(5), 32'd0, TW'(5), 32'd0, 3'b000, 1'b0, TW'(6));
    applyBroadcast(TW'(5), 32'h33);
    testsRun++;
    if (dut.v1_q !== 32'h33 || dut.v2_q !== 32'h33 || ifc.ready_to_execute !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL both_snoop: got v1=%0h v2=%0h ready=%0h want 33 33 1",
               dut.v1_q, dut.v2_q, ifc.ready_to_execute);
    end
    @(negedge clk);
    ifc.cdb_permit = 1'b1;
    ifc.cdb_valid  = 1'b1;
    #1;
    testsRun++;
    if (cdbData !== 32'h66 || cdbRobTag !== TW'(6)) begin
      testsFailed++;
      $display("[TB] FAIL both_result: got data=%0h tag=%0d want 66 6", cdbData, cdbRobTag);
    end
    @(negedge clk);
    ifc.cdb_permit = 1'b0;
    ifc.cdb_valid  = 1'b0;
  endtask

  task automatic test_alu();
    logic [XLEN-1:0] aVals [11];
    logic [XLEN-1:0] bVals [11];
    logic [2:0]      f3s   [11];
    logic            sgns  [11];
    logic [XLEN-1:0] exps  [11];
    aVals = '{32'd3, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
              32'h8000_0000, 32'h8000_0000, 32'h0000_00F0, 32'hFF00_FF00, 32'hFFFF_FFFF};
    bVals = '{32'd4, 32'd7, 32'h23, 32'd1, 32'd1, 32'h0FF0_0FF0,
              32'd4, 32'd4, 32'h0000_0F00, 32'h0FF0_0FF0, 32'd2};
    f3s   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    sgns  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exps  = '{32'd7, 32'hFFFF_FFFE, 32'd8, 32'd1, 32'd0, 32'hFF00_FF00,
              32'h0800_0000, 32'hF800_0000, 32'h0000_0FF0, 32'h0F00_0F00, 32'd1};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(TW'(0), aVals[i], TW'(0), bVals[i], f3s[i], sgns[i], TW'(100 + i));
      @(negedge clk);
      ifc.cdb_permit = 1'b1;
      ifc.cdb_valid  = 1'b1;
      #1;
      testsRun++;
      if (cdbData !== exps[i] || cdbRobTag !== TW'(100 + i)) begin
        testsFailed++;
        $display("[TB] FAIL alu_op%0d: got data=%h tag=%0d want %h %0d",
                 i, cdbData, cdbRobTag, exps[i], 100 + i);
      end
      @(negedge clk);
      ifc.cdb_permit = 1'b0;
      ifc.cdb_valid  = 1'b0;
    end
  endtask

  task automatic test_fifo_full();
    // Fill the FIFO without a grant, freeing the station by broadcasting
    // each tag ourselves so the next instruction can issue.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(TW'(0), XLEN'(i), TW'(0), 32'd100, 3'b000, 1'b0, TW'(40 + i));
      @(negedge clk);
      applyBroadcast(TW'(40 + i), 32'd0);
    end
    testsRun++;
    if (dut.count_q !== 3'(DEPTH) || ifc.buf_not_empty !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fifo_fill: got count=%0d bne=%0h want %0d 1", dut.count_q, ifc.buf_not_empty, DEPTH);
    end
    applyStimulus(TW'(0), 32'd4, TW'(0), 32'd100, 3'b000, 1'b0, TW'(50));
    @(negedge clk);
    testsRun++;
    if (ifc.ready_to_execute !== 1'b1 || dut.dispatched_q !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fifo_full_hold: got ready=%0h disp=%0h want 1 0",
               ifc.ready_to_execute, dut.dispatched_q);
    end
    ifc.cdb_permit = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      #1;
      testsRun++;
      if (cdbData !== XLEN'(100 + k) || cdbRobTag !== TW'((k < DEPTH) ? 40 + k : 50)) begin
        testsFailed++;
        $display("[TB] FAIL fifo_order%0d: got data=%0d tag=%0d want %0d %0d",
                 k, cdbData, cdbRobTag, 100 + k, (k < DEPTH) ? 40 + k : 50);
      end
      @(negedge clk);
    end
    ifc.cdb_permit = 1'b0;
    testsRun++;
    if (ifc.buf_not_empty !== 1'b0 || dut.dispatched_q !== 1'b1 || ifc.busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fifo_drained: got bne=%0h disp=%0h busy=%0h want 0 1 1",
               ifc.buf_not_empty, dut.dispatched_q, ifc.busy);
    end
    applyBroadcast(TW'(50), 32'd0);
    testsRun++;
    if (ifc.busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL fifo_final_free: got busy=%0h want 0", ifc.busy);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(TW'(0), 32'd1, TW'(0), 32'd2, 3'b000, 1'b0, TW'(60));
    @(negedge clk);
    testsRun++;
    if (ifc.busy !== 1'b1 || ifc.buf_not_empty !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL areset_pre: got busy=%0h bne=%0h want 1 1", ifc.busy, ifc.buf_not_empty);
    end
    #2 reset = 1'b0;
    #1;
    testsRun++;
    if (ifc.busy !== 1'b0 || ifc.buf_not_empty !== 1'b0 || ifc.ready_to_execute !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL areset_status: got busy=%0h bne=%0h ready=%0h want 0 0 0",
               ifc.busy, ifc.buf_not_empty, ifc.ready_to_execute);
    end
    testsRun++;
    if (dut.tag_q !== TW'(0) || dut.count_q !== 3'd0 || dut.v1_q !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL areset_fields: got tag=%0d count=%0d v1=%0d want 0 0 0",
               dut.tag_q, dut.count_q, dut.v1_q);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if (ifc.busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL areset_post: got busy=%0h want 0", ifc.busy);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset          = 1'b0;
    tbDrive        = 1'b0;
    tbTag          = '0;
    tbData         = '0;
    ifc.enable     = 1'b0;
    ifc.q1_in      = '0;
    ifc.v1_in      = '0;
    ifc.q2_in      = '0;
    ifc.v2_in      = '0;
    ifc.funct3_in  = '0;
    ifc.sign_in    = 1'b0;
    ifc.rob_tag_in = '0;
    ifc.cdb_valid  = 1'b0;
    ifc.cdb_permit = 1'b0;

    test_reset();
    test_issue();
    test_snoop();
    test_drain_free();
    test_both_operands();
    test_alu();
    test_fifo_full();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
